// File: rtl/branch_predictor_table.sv
// ---------------------------------------------------------------------------
// branch_predictor_table
//   Branch direction predictor built from a table of saturating counters.
//   Bimodal when HIST_BITS = 0; gshare when HIST_BITS > 0, with a global
//   history register that is updated only when branches resolve.
//
//   Ports
//     clk, reset          : single clock, asynchronous active-high reset
//     lookup_valid        : decode-stage instruction is a conditional branch
//     lookup_pc           : PC of the decode-stage instruction
//     lookup_offset       : sign-extended branch immediate
//     prediction          : predict taken (qualified by lookup_valid)
//     branch_addr         : lookup_pc + lookup_offset
//     lookup_index        : table index used for this lookup (pipelined to MEM)
//     update_valid        : a branch resolves this cycle
//     update_index        : pipelined lookup_index of the resolving branch
//     update_taken        : actual outcome
//     update_mispredict   : resolving branch was mispredicted
//     mispredict_count    : saturating mispredict statistics counter
// ---------------------------------------------------------------------------
module branch_predictor_table #(
    parameter int unsigned ENTRIES   = 64,
    parameter int unsigned HIST_BITS = 0,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned IDX_W    = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [31:0]       lookup_pc,
    input  logic [31:0]       lookup_offset,
    output logic              prediction,
    output logic [31:0]       branch_addr,
    output logic [IDX_W-1:0]  lookup_index,
    input  logic              update_valid,
    input  logic [IDX_W-1:0]  update_index,
    input  logic              update_taken,
    input  logic              update_mispredict,
    output logic [CNT_W-1:0]  mispredict_count
);

    // The history register keeps at least one bit so the declaration stays
    // legal in bimodal mode; it is held at zero and masked out there.
    localparam int unsigned GHR_W = (HIST_BITS > 0) ? HIST_BITS : 1;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    // Weakly not-taken: 2^(CTR_BITS-1)-1, which is 0 for 1-bit counters.
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d [ENTRIES];
    logic [GHR_W-1:0]    ghr_q;
    logic [GHR_W-1:0]    ghr_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [IDX_W-1:0]    ghr_ext;

    // Lookup path is purely combinational off the registered state, so a
    // same-cycle update is never forwarded into the prediction.
    assign ghr_ext          = (HIST_BITS > 0) ? IDX_W'(ghr_q) : '0;
    assign lookup_index     = lookup_pc[IDX_W+1:2] ^ ghr_ext;
    assign branch_addr      = lookup_pc + lookup_offset;
    assign prediction       = lookup_valid & ctr_q[lookup_index][CTR_BITS-1];
    assign mispredict_count = cnt_q;

    always_comb begin
        ctr_d = ctr_q;
        ghr_d = ghr_q;
        cnt_d = cnt_q;
        if (update_valid) begin
            if (update_taken) begin
                if (ctr_q[update_index] != CTR_MAX) begin
                    ctr_d[update_index] = ctr_q[update_index] + 1'b1;
                end
            end else begin
                if (ctr_q[update_index] != '0) begin
                    ctr_d[update_index] = ctr_q[update_index] - 1'b1;
                end
            end
            // Shift in the outcome; truncation drops the oldest bit.
            if (HIST_BITS > 0) begin
                ghr_d = GHR_W'({ghr_q, update_taken});
            end
            if (update_mispredict && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
            ghr_q <= '0;
            cnt_q <= '0;
        end else begin
            ctr_q <= ctr_d;
            ghr_q <= ghr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor_table.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_table
//   Two instances share one stimulus stream: a default bimodal predictor and
//   a gshare predictor (HIST_BITS=2, CNT_W=4). A behavioural model of both
//   is compared against the outputs every falling edge, and directed
//   scenarios pin literal expected values.
// ---------------------------------------------------------------------------
module tb_branch_predictor_table;

    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic [31:0] lookup_offset;
    logic        update_valid;
    logic [5:0]  update_index;
    logic        update_taken;
    logic        update_mispredict;

    logic        pred_a, pred_b;
    logic [31:0] addr_a, addr_b;
    logic [5:0]  idx_a, idx_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    branch_predictor_table dut_a (
        .clk               (clk),
        .reset             (reset),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .lookup_offset     (lookup_offset),
        .prediction        (pred_a),
        .branch_addr       (addr_a),
        .lookup_index      (idx_a),
        .update_valid      (update_valid),
        .update_index      (update_index),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict),
        .mispredict_count  (cnt_a)
    );

    branch_predictor_table #(
        .ENTRIES   (64),
        .HIST_BITS (2),
        .CTR_BITS  (2),
        .CNT_W     (4)
    ) dut_b (
        .clk               (clk),
        .reset             (reset),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .lookup_offset     (lookup_offset),
        .prediction        (pred_b),
        .branch_addr       (addr_b),
        .lookup_index      (idx_b),
        .update_valid      (update_valid),
        .update_index      (update_index),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict),
        .mispredict_count  (cnt_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_ctr_a [64];
    int m_ctr_b [64];
    int m_ghr_b;
    int m_cnt_a;
    int m_cnt_b;

    function automatic int bump(input int c, input bit up);
        if (up) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                m_ctr_a[i] = 1;
                m_ctr_b[i] = 1;
            end
            m_ghr_b = 0;
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (update_valid) begin
            m_ctr_a[update_index] = bump(m_ctr_a[update_index], update_taken);
            m_ctr_b[update_index] = bump(m_ctr_b[update_index], update_taken);
            m_ghr_b = (m_ghr_b * 2 + int'(update_taken)) % 4;
            if (update_mispredict) begin
                if (m_cnt_a < 65535) m_cnt_a = m_cnt_a + 1;
                if (m_cnt_b < 15)    m_cnt_b = m_cnt_b + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            int e_idx_a;
            int e_idx_b;
            e_idx_a = int'((lookup_pc / 4) % 64);
            e_idx_b = e_idx_a ^ m_ghr_b;
            chk("model_idx_a",  32'(idx_a),  32'(e_idx_a));
            chk("model_idx_b",  32'(idx_b),  32'(e_idx_b));
            chk("model_addr_a", addr_a, lookup_pc + lookup_offset);
            chk("model_addr_b", addr_b, lookup_pc + lookup_offset);
            chk("model_pred_a", 32'(pred_a), 32'(lookup_valid && m_ctr_a[e_idx_a] >= 2));
            chk("model_pred_b", 32'(pred_b), 32'(lookup_valid && m_ctr_b[e_idx_b] >= 2));
            chk("model_cnt_a",  32'(cnt_a),  32'(m_cnt_a));
            chk("model_cnt_b",  32'(cnt_b),  32'(m_cnt_b));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input bit v, input logic [5:0] i, input bit t, input bit m);
        update_valid      = v;
        update_index      = i;
        update_taken      = t;
        update_mispredict = m;
    endtask

    task automatic look(input bit v, input logic [31:0] pc, input logic [31:0] off);
        lookup_valid  = v;
        lookup_pc     = pc;
        lookup_offset = off;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        bit          uv;
        logic [5:0]  ui;
        bit          ut;
        bit          um;
        bit          lv;
        logic [31:0] pc;
        logic [31:0] off;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 6'd2,  1'b0, 1'b0, 1'b1, 32'h0000_0108, 32'h0000_0000};
        vecs[1] = '{1'b1, 6'd2,  1'b1, 1'b0, 1'b1, 32'h0000_0108, 32'hFFFF_FFF0};
        vecs[2] = '{1'b1, 6'd2,  1'b1, 1'b1, 1'b1, 32'h0000_0108, 32'h0000_0004};
        vecs[3] = '{1'b0, 6'd2,  1'b0, 1'b1, 1'b1, 32'h0000_0108, 32'h0000_0000};
        vecs[4] = '{1'b1, 6'd63, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0008};
        vecs[5] = '{1'b1, 6'd63, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[6] = '{1'b1, 6'd63, 1'b0, 1'b1, 1'b1, 32'h0000_01FC, 32'h0000_0100};
        vecs[7] = '{1'b1, 6'd0,  1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0000};

        reset = 1'b1;
        upd(1'b0, 6'd0, 1'b0, 1'b0);
        look(1'b0, 32'h0, 32'h0);
        tick();
        cmp_en = 1'b1;
        tick();
        chk("reset_cnt_a", 32'(cnt_a), 32'd0);
        reset = 1'b0;

        // Untrained lookup
        look(1'b1, 32'h0000_0104, 32'h0000_0020);
        #1;
        chk("lit_pred_reset", 32'(pred_a), 32'd0);
        chk("lit_addr",       addr_a, 32'h0000_0124);
        chk("lit_idx",        32'(idx_a), 32'h01);

        // Train index 1: 01 -> 10 -> 11 -> 11 -> 10
        upd(1'b1, 6'd1, 1'b1, 1'b0);
        tick();
        #1;
        chk("lit_pred_after_1st", 32'(pred_a), 32'd1);
        tick();
        tick();
        upd(1'b1, 6'd1, 1'b0, 1'b0);
        tick();
        upd(1'b0, 6'd0, 1'b0, 1'b0);
        #1;
        chk("lit_pred_after_nt", 32'(pred_a), 32'd1);
        tick();

        // No write-through on a same-cycle lookup/update
        do_reset();
        look(1'b1, 32'h0000_0104, 32'h0000_0020);
        upd(1'b1, 6'd1, 1'b1, 1'b0);
        #1;
        chk("lit_pred_same_cycle", 32'(pred_a), 32'd0);
        tick();
        upd(1'b0, 6'd0, 1'b0, 1'b0);
        #1;
        chk("lit_pred_next_cycle", 32'(pred_a), 32'd1);
        tick();

        // gshare history
        do_reset();
        upd(1'b1, 6'd0, 1'b1, 1'b0);
        tick();
        tick();
        upd(1'b0, 6'd0, 1'b0, 1'b0);
        look(1'b1, 32'h0000_0104, 32'h0);
        #1;
        chk("lit_gshare_idx",  32'(idx_b), 32'h02);
        chk("lit_bimodal_idx", 32'(idx_a), 32'h01);
        chk("lit_gshare_pred", 32'(pred_b), 32'd0);
        tick();

        // Mispredict counter saturation
        do_reset();
        upd(1'b1, 6'd5, 1'b0, 1'b1);
        repeat (20) tick();
        upd(1'b0, 6'd5, 1'b1, 1'b1);
        #1;
        chk("lit_cnt_b_sat", 32'(cnt_b), 32'd15);
        chk("lit_cnt_a_20",  32'(cnt_a), 32'd20);
        repeat (5) tick();
        chk("lit_cnt_b_hold", 32'(cnt_b), 32'd15);
        chk("lit_cnt_a_hold", 32'(cnt_a), 32'd20);

        // Directed vectors checked by the model
        do_reset();
        foreach (vecs[k]) begin
            upd(vecs[k].uv, vecs[k].ui, vecs[k].ut, vecs[k].um);
            look(vecs[k].lv, vecs[k].pc, vecs[k].off);
            tick();
        end
        upd(1'b0, 6'd0, 1'b0, 1'b0);
        look(1'b1, 32'hFFFF_FFFC, 32'h0000_0008);
        #1;
        chk("lit_addr_wrap", addr_a, 32'h0000_0004);
        tick();

        // Asynchronous mid-cycle reset
        do_reset();
        upd(1'b1, 6'd1, 1'b1, 1'b1);
        repeat (3) tick();
        upd(1'b0, 6'd0, 1'b0, 1'b0);
        look(1'b1, 32'h0000_0104, 32'h0);
        #1;
        chk("lit_trained_pred", 32'(pred_a), 32'd1);
        chk("lit_trained_cnt",  32'(cnt_a),  32'd3);
        reset = 1'b1;
        #1;
        chk("lit_async_pred",  32'(pred_a), 32'd0);
        chk("lit_async_cnt_a", 32'(cnt_a),  32'd0);
        chk("lit_async_cnt_b", 32'(cnt_b),  32'd0);
        upd(1'b1, 6'd1, 1'b1, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        upd(1'b0, 6'd0, 1'b0, 1'b0);
        #1;
        chk("lit_post_reset_pred", 32'(pred_a), 32'd0);
        chk("lit_post_reset_cnt",  32'(cnt_a),  32'd0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor_table.md
BRANCH_PREDICTOR_TABLE -- requirements
Module: branch_predictor_table

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, giving the number of counter-table entries; power of 2, range 2..1024; IDX_W = log2(ENTRIES).
REQ-002 SHALL have parameter HIST_BITS, default 0, giving the global-history length; range 0..IDX_W; 0 selects bimodal mode, >0 selects gshare mode.
REQ-003 SHALL have parameter CTR_BITS, default 2, giving the saturating-counter width; range 1..4.
REQ-004 SHALL have parameter CNT_W, default 16, giving the mispredict statistics counter width.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 lookup_valid  input  1  decode-stage instruction is a conditional branch.
REQ-008 lookup_pc  input  32  PC of the decode-stage instruction.
REQ-009 lookup_offset  input  32  sign-extended branch immediate.
REQ-010 prediction  output  1  predict taken.
REQ-011 branch_addr  output  32  predicted target address.
REQ-012 lookup_index  output  IDX_W  table index used for this lookup; the CPU pipelines it to MEM.
REQ-013 update_valid  input  1  a branch resolves in the MEM stage this cycle.
REQ-014 update_index  input  IDX_W  pipelined lookup_index of the resolving branch.
REQ-015 update_taken  input  1  actual branch outcome.
REQ-016 update_mispredict  input  1  resolving branch was mispredicted.
REQ-017 mispredict_count  output  CNT_W  saturating count of mispredicts.

Function
REQ-018 lookup_index SHALL equal lookup_pc[IDX_W+1:2] XOR ghr, with ghr zero-extended to IDX_W bits; ghr is treated as 0 when HIST_BITS=0.
REQ-019 branch_addr SHALL equal lookup_pc + lookup_offset modulo 2^32, combinationally, independent of lookup_valid.
REQ-020 prediction SHALL equal lookup_valid AND the MSB of counter[lookup_index], combinationally, with no added latency.
REQ-021 On a clock edge with update_valid=1, counter[update_index] SHALL increment if update_taken=1 and decrement otherwise, saturating at 2^CTR_BITS-1 and at 0.
REQ-022 On a clock edge with update_valid=1 and HIST_BITS>0, ghr SHALL become {ghr[HIST_BITS-2:0], update_taken}; for HIST_BITS=1 it SHALL become update_taken.
REQ-023 ghr SHALL be updated only at resolution (non-speculative); lookups never modify state.
REQ-024 On a clock edge with update_valid=1 and update_mispredict=1, mispredict_count SHALL increment, holding at 2^CNT_W-1 once reached.
REQ-025 update_taken and update_mispredict SHALL be ignored when update_valid=0.
REQ-026 A lookup and an update to the same index in the same cycle SHALL return the pre-update counter value (no write-through); the new value SHALL be visible from the next cycle.
REQ-027 A same-cycle lookup SHALL use the pre-update ghr.
REQ-028 Every counter SHALL be an independent register, readable combinationally; no RAM inference is required.

Reset
REQ-029 While reset=1, every counter SHALL be 2^(CTR_BITS-1)-1 (weakly not-taken; 0 when CTR_BITS=1), ghr SHALL be 0, and mispredict_count SHALL be 0, regardless of clk.
REQ-030 Reset asserted mid-operation SHALL discard all training immediately; an update_valid coincident with reset SHALL have no effect.
REQ-031 After reset, prediction SHALL be 0 for every lookup until training occurs.

Verification
REQ-032 Defaults; reset, then lookup_valid=1, pc=0x104, offset=0x20 -> prediction=0, branch_addr=0x124, lookup_index=0x01.
REQ-033 Defaults; updates to index 1: taken, taken, taken, not-taken -> counter 01->10->11->11->10; a lookup at pc=0x104 predicts 1 after the first update and still predicts 1 at the end.
REQ-034 Defaults; counter[1]=01, same-cycle lookup of pc=0x104 with taken update to index 1 -> prediction=0 that cycle and 1 the next cycle.
REQ-035 HIST_BITS=2; two taken updates to index 0 -> ghr=0b11; a lookup at pc=0x104 gives lookup_index=0x02.
REQ-036 CNT_W=4; 20 updates with update_mispredict=1 -> mispredict_count holds 15; 5 updates with update_valid=0, update_mispredict=1 -> count unchanged.
REQ-037 Train index 1 to 11, assert reset asynchronously between edges -> counter reads 01, prediction=0, mispredict_count=0 immediately.
